acc_tx_serializer: RTL

- Downstream consumer of the unsigned accumulator: takes one accumulator result (data word plus carry) per handshake and shifts it out on a single-wire, UART-style serial line.
- Lets the accumulator result leave the FPGA on one pin.
- Built from a valid/ready capture register, a bit-period divider and a frame FSM.

---
 rtl/acc_tx_serializer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/acc_tx_serializer.sv
// UART-style serializer for one accumulator result (data + carry) per valid/ready handshake.
// Optional even-parity bit between carry and stop when ACC_TX_PARITY_EN is defined.
module acc_tx_serializer #(
  parameter int DATA_W  = 6,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_carry,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_tx,
  output logic              o_busy,
  output logic              o_done
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_CARRY,
`ifdef ACC_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [DIV_W-1:0]  r_div, w_div_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0] r_shift, w_shift_nxt;
  logic              r_carry, w_carry_nxt;
  logic              r_tx, w_tx_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              r_ready, w_ready_nxt;
  logic              w_bit_end;
  logic [DATA_W-1:0] w_shift_sr;
`ifdef ACC_TX_PARITY_EN
  logic              r_par, w_par_nxt;
`endif

  assign w_bit_end  = (r_div == DIV_LAST);
  assign w_shift_sr = r_shift >> 1;

  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = '0;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_carry_nxt = r_carry;
    w_tx_nxt    = r_tx;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_ready_nxt = r_ready;
`ifdef ACC_TX_PARITY_EN
    w_par_nxt   = r_par;
`endif
    if (r_state != S_IDLE) begin
      w_div_nxt = w_bit_end ? '0 : r_div + 1'b1;
    end
    // tx is loaded one edge ahead so the line always comes straight from a flop
    case (r_state)
      S_IDLE: begin
        w_ready_nxt = 1'b1;
        if (r_ready && i_valid) begin
          w_state_nxt = S_START;
          w_shift_nxt = i_data;
          w_carry_nxt = i_carry;
          w_tx_nxt    = 1'b0;
          w_busy_nxt  = 1'b1;
          w_ready_nxt = 1'b0;
`ifdef ACC_TX_PARITY_EN
          w_par_nxt   = ^{i_data, i_carry};
`endif
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_nxt = S_DATA;
          w_cnt_nxt   = '0;
          w_tx_nxt    = r_shift[0];
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (r_cnt == CNT_LAST) begin
            w_state_nxt = S_CARRY;
            w_tx_nxt    = r_carry;
          end else begin
            w_cnt_nxt   = r_cnt + 1'b1;
            w_shift_nxt = w_shift_sr;
            w_tx_nxt    = w_shift_sr[0];
          end
        end
      end
      S_CARRY: begin
        if (w_bit_end) begin
`ifdef ACC_TX_PARITY_EN
          w_state_nxt = S_PARITY;
          w_tx_nxt    = r_par;
`else
          w_state_nxt = S_STOP;
          w_tx_nxt    = 1'b1;
`endif
        end
      end
`ifdef ACC_TX_PARITY_EN
      S_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = S_STOP;
          w_tx_nxt    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (w_bit_end) begin
          w_state_nxt = S_IDLE;
          w_tx_nxt    = 1'b1;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_ready_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tx_nxt    = 1'b1;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_cnt   <= '0;
      r_shift <= '0;
      r_carry <= 1'b0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b0;
`ifdef ACC_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_div_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
      r_carry <= w_carry_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_ready <= w_ready_nxt;
`ifdef ACC_TX_PARITY_EN
      r_par   <= w_par_nxt;
`endif
    end
  end

  assign o_tx    = r_tx;
  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_ready = r_ready;

endmodule
